// File: rtl/hwag_ch_sched.sv
// hwag_ch_sched -- angle-domain channel scheduler.
//
// Drives CH_NUM outputs that switch on at a programmable set angle and off at
// a programmable reset angle of the running crank angle. One crossing
// comparator is shared round-robin across the channels. Angles are written to
// pending registers and copied to the active set at the angle wrap (or at any
// time while the angle generator is stopped), so timing can be changed on the
// fly without glitches.
//
// Ports:
//   clk, rst         single clock, synchronous active-high reset
//   hwag_start       angle valid; low stops scheduling and clears outputs
//   acnt             current angle, 0..ANGLE_TOP
//   wr_ena/addr/data pending register write, addr = {channel, sel}
//                    (sel 0 = set angle, 1 = reset angle)
//   wr_err           one-cycle pulse, write dropped because data > ANGLE_TOP
//   upd_req          request a commit of pending to active registers
//   upd_pend         commit requested but not yet applied
//   ch_out           channel outputs
//
// Optional feature macro HWAG_SCHED_FORCE_EN: adds force_ena/force_val ports
// that override ch_out per channel after the output register.

module hwag_ch_sched #(
  parameter int unsigned CH_NUM      = 4,
  parameter int unsigned ANGLE_WIDTH = 24,
  parameter int unsigned ANGLE_TOP   = 7679
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      hwag_start,
  input  logic [ANGLE_WIDTH-1:0]    acnt,
  input  logic                      wr_ena,
  input  logic [$clog2(CH_NUM):0]   wr_addr,
  input  logic [ANGLE_WIDTH-1:0]    wr_data,
  output logic                      wr_err,
  input  logic                      upd_req,
  output logic                      upd_pend,
`ifdef HWAG_SCHED_FORCE_EN
  input  logic [CH_NUM-1:0]         force_ena,
  input  logic [CH_NUM-1:0]         force_val,
`endif
  output logic [CH_NUM-1:0]         ch_out
);

  localparam int unsigned SW = $clog2(CH_NUM);
  localparam logic [ANGLE_WIDTH-1:0] TOP       = ANGLE_WIDTH'(ANGLE_TOP);
  localparam logic [SW-1:0]          SIDX_LAST = SW'(CH_NUM - 1);

  typedef logic [ANGLE_WIDTH-1:0] angle_t;

  angle_t            acnt_q, acnt_d;
  angle_t            acnt_prev_q, acnt_prev_d;
  logic [SW-1:0]     sidx_q, sidx_d;
  angle_t            pend_set_q [CH_NUM];
  angle_t            pend_set_d [CH_NUM];
  angle_t            pend_rst_q [CH_NUM];
  angle_t            pend_rst_d [CH_NUM];
  angle_t            act_set_q  [CH_NUM];
  angle_t            act_set_d  [CH_NUM];
  angle_t            act_rst_q  [CH_NUM];
  angle_t            act_rst_d  [CH_NUM];
  angle_t            last_q     [CH_NUM];
  angle_t            last_d     [CH_NUM];
  logic [CH_NUM-1:0] ch_q, ch_d;
  logic              upd_pend_q, upd_pend_d;
  logic              wr_err_q, wr_err_d;

  logic              wrap;
  logic              commit;
  logic [SW-1:0]     wr_ch;
  logic              wr_sel;
  logic              wr_ch_ok;
  logic              set_x;
  logic              rst_x;

  // Window crossing: angle a lies in (last, cur], with the window wrapping
  // through zero when cur < last. An unchanged angle crosses nothing.
  function automatic logic crossed(input angle_t a, input angle_t last,
                                   input angle_t cur);
    if (cur > last) begin
      return (a > last) && (a <= cur);
    end else if (cur < last) begin
      return (a > last) || (a <= cur);
    end else begin
      return 1'b0;
    end
  endfunction

  assign wr_ch    = wr_addr[SW:1];
  assign wr_sel   = wr_addr[0];
  assign wr_ch_ok = ({1'b0, wr_ch} < (SW+1)'(CH_NUM));

  always_comb begin
    acnt_d      = acnt;
    acnt_prev_d = acnt_q;
    pend_set_d  = pend_set_q;
    pend_rst_d  = pend_rst_q;
    act_set_d   = act_set_q;
    act_rst_d   = act_rst_q;
    last_d      = last_q;
    ch_d        = ch_q;
    wr_err_d    = 1'b0;
    set_x       = 1'b0;
    rst_x       = 1'b0;

    // Scan index
    if (!hwag_start) begin
      sidx_d = '0;
    end else if (sidx_q == SIDX_LAST) begin
      sidx_d = '0;
    end else begin
      sidx_d = sidx_q + SW'(1);
    end

    // Pending register writes
    if (wr_ena) begin
      if (wr_data > TOP) begin
        wr_err_d = 1'b1;
      end else if (wr_ch_ok) begin
        for (int unsigned i = 0; i < CH_NUM; i++) begin
          if (wr_ch == SW'(i)) begin
            if (wr_sel) begin
              pend_rst_d[i] = wr_data;
            end else begin
              pend_set_d[i] = wr_data;
            end
          end
        end
      end
    end

    // Commit uses the post-write pending values so a write in the commit
    // cycle is included; an upd_req in that cycle re-arms upd_pend.
    wrap   = (acnt_q < acnt_prev_q);
    commit = (upd_pend_q | upd_req) & (wrap | ~hwag_start);
    if (commit) begin
      act_set_d = pend_set_d;
      act_rst_d = pend_rst_d;
    end
    upd_pend_d = commit ? upd_req : (upd_pend_q | upd_req);

    // Evaluate / update stage
    if (!hwag_start) begin
      ch_d = '0;
      for (int unsigned i = 0; i < CH_NUM; i++) begin
        last_d[i] = acnt_q;
      end
    end else begin
      for (int unsigned i = 0; i < CH_NUM; i++) begin
        if (sidx_q == SW'(i)) begin
          set_x = crossed(act_set_q[i], last_q[i], acnt_q);
          rst_x = crossed(act_rst_q[i], last_q[i], acnt_q);
          if (rst_x) begin
            ch_d[i] = 1'b0;
          end else if (set_x) begin
            ch_d[i] = 1'b1;
          end
          last_d[i] = acnt_q;
        end
      end
    end

    // set == reset disables the channel
    for (int unsigned i = 0; i < CH_NUM; i++) begin
      if (act_set_q[i] == act_rst_q[i]) begin
        ch_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acnt_q      <= '0;
      acnt_prev_q <= '0;
      sidx_q      <= '0;
      ch_q        <= '0;
      upd_pend_q  <= 1'b0;
      wr_err_q    <= 1'b0;
      for (int unsigned i = 0; i < CH_NUM; i++) begin
        pend_set_q[i] <= '0;
        pend_rst_q[i] <= '0;
        act_set_q[i]  <= '0;
        act_rst_q[i]  <= '0;
        last_q[i]     <= '0;
      end
    end else begin
      acnt_q      <= acnt_d;
      acnt_prev_q <= acnt_prev_d;
      sidx_q      <= sidx_d;
      ch_q        <= ch_d;
      upd_pend_q  <= upd_pend_d;
      wr_err_q    <= wr_err_d;
      pend_set_q  <= pend_set_d;
      pend_rst_q  <= pend_rst_d;
      act_set_q   <= act_set_d;
      act_rst_q   <= act_rst_d;
      last_q      <= last_d;
    end
  end

  assign wr_err   = wr_err_q;
  assign upd_pend = upd_pend_q;

`ifdef HWAG_SCHED_FORCE_EN
  // Override sits after the register so it also works while stopped; the
  // scheduled state in ch_q keeps running underneath.
  assign ch_out = (force_ena & force_val) | (~force_ena & ch_q);
`else
  assign ch_out = ch_q;
`endif

endmodule

// File: doc/hwag_ch_sched.md
# hwag_ch_sched

Angle-domain channel scheduler for the hardware angle generator. It takes the running crank angle and drives CH_NUM output channels, each switched on and off at a programmable set and reset angle. One shared crossing comparator is time-multiplexed round-robin across all channels. Angle pairs are written into pending registers and committed to the active set atomically at the angle wrap, so ignition/injection timing can be reprogrammed on the fly without glitches.

## Interface
- CH_NUM, 4: number of output channels, 2..16.
- ANGLE_WIDTH, 24: width of the angle input and the angle registers.
- ANGLE_TOP, 7679: last angle value before wrap to 0 (720° at 64 counts/tooth).
- clk  in  1  module clock; single clock domain.
- rst  in  1  reset, synchronous, active-high.
- hwag_start  in  1  angle generator synchronised; low means the angle is invalid.
- acnt  in  ANGLE_WIDTH  current angle, 0..ANGLE_TOP, synchronous to clk.
- wr_ena  in  1  write strobe for the pending angle registers.
- wr_addr  in  $clog2(CH_NUM)+1  {channel, sel}; sel 0 = set angle, 1 = reset angle.
- wr_data  in  ANGLE_WIDTH  angle value to write.
- wr_err  out  1  one-cycle pulse: write rejected because wr_data > ANGLE_TOP.
- upd_req  in  1  pulse: request commit of pending to active registers.
- upd_pend  out  1  commit requested and not yet applied.
- ch_out  out  CH_NUM  channel outputs.

## Operation
- acnt_q <= acnt every clk. Wrap is detected when acnt_q < previous acnt_q.
- Scan index sidx cycles 0..CH_NUM-1, advancing by one each clk while hwag_start = 1. It is held at 0 otherwise.
- Evaluate stage: read the active set[sidx], rst[sidx] and last[sidx] registers. Angle a has crossed if:
  - cur >= last: last < a <= cur;
  - cur < last (wrapped): a > last or a <= cur;
  - cur == last: never crossed.
- Update stage, registered:
  - reset crossed: ch_out[sidx] <= 0 (reset wins if both crossed);
  - else set crossed: ch_out[sidx] <= 1;
  - else hold;
  - last[sidx] <= cur in every case.
- A channel with set == reset is disabled, and its ch_out is forced to 0.
- Writes go only to the pending registers. Writes with an out-of-range value are dropped, and wr_err pulses.
- upd_req sets upd_pend. Commit copies all pending to active and clears upd_pend. Commit happens on:
  - a detected wrap, or
  - any cycle with hwag_start = 0.
- Simultaneous events:
  - a write in the commit cycle is included in the commit;
  - upd_req in the commit cycle commits and leaves upd_pend = 1.
- While hwag_start = 0:
  - ch_out = 0;
  - every last[i] <= acnt_q, so no spurious crossing occurs on start.

## Timing
- Reset values: ch_out = 0, upd_pend = 0, wr_err = 0, sidx = 0, acnt_q = 0, all pending/active/last = 0 (all channels disabled).
- Latency from a change on acnt to ch_out is 2 clocks minimum and CH_NUM+1 clocks maximum.
- Multiple angle steps inside one scan period are handled by window crossing, not equality, so no event is missed.
- The wr_err pulse appears 1 clk after wr_ena. A pending write is readable by commit in the same cycle.
- The commit takes effect for the evaluation performed in the clock after wrap detection.
- hwag_start falling forces ch_out = 0 on the next clk, mid-pulse if necessary.
- rst mid-operation returns every register to its reset value on the next clk edge.

## Configuration
- HWAG_SCHED_FORCE_EN defined:
  - adds ports force_ena (in, CH_NUM) and force_val (in, CH_NUM);
  - ch_out[i] = force_ena[i] ? force_val[i] : the scheduled value;
  - the override is combinational after the output register and works regardless of hwag_start;
  - the scheduled state keeps updating underneath.
- HWAG_SCHED_FORCE_EN undefined: these ports do not exist, and ch_out is the scheduled register directly.

## Test plan
- Program ch0 set = 1152, reset = 1216, then upd_req. Ramp acnt 0..7679 by 1 every 8 clk -> ch0 rises within 5 clk of acnt = 1152, falls within 5 clk of 1216, and upd_pend clears at the first wrap.
- Ch1 set = 7600, reset = 64 (spans the wrap). Step acnt by 37 -> ch1 high from 7622 through wrap, low at acnt = 74.
- Ch2 set = 3072, reset = 3136. Jump acnt from 3000 to 3200 in one clk -> both crossed, ch2 stays 0.
- Write ch0 set = 8000 -> wr_err pulse, pending unchanged. Write new angles mid-revolution -> active values unchanged until wrap, and the old pulse completes.
- Drop hwag_start while ch3 is high -> ch3 = 0 next clk. Reassert with acnt = 5000 and set = 4992 -> no pulse until the next revolution.
- With HWAG_SCHED_FORCE_EN: force_ena = 4'b0001, force_val = 4'b0001 with hwag_start = 0 -> ch_out = 4'b0001.
